// File: rtl/word_byte_writer.sv
// word_byte_writer: splits a captured 16-bit word into two byte writes
// (or one, in single mode) on a byte-wide memory port with a ready handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; outputs hold the last driven address/data
// S_BYTE0 | first byte of the selected order presented at base address
// S_BYTE1 | second byte presented at base+1 (modulo 2^ADDR_W)
// S_DONE  | one-cycle completion pulse, then back to idle
module word_byte_writer #(
  parameter int ADDR_W   = 8,
  parameter bit HI_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              single,
  input  logic [15:0]       word_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              mem_ready,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BYTE0 = 2'd1;
  localparam logic [1:0] S_BYTE1 = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [15:0]       word_q;
  logic [ADDR_W-1:0] addr_q;
  logic              single_q;
  // Which half of word_q and which address offset are on the port; held
  // outside the write states so address/data keep their last driven values.
  logic              hi_sel_q;
  logic              off_q;
  logic              accept;
  logic              adv_byte1;

  assign accept    = (state == S_IDLE) && start;
  assign adv_byte1 = (state == S_BYTE0) && mem_ready && !single_q;

  // Next-state selection; mem_ready only matters while a write is presented.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_BYTE0;
      S_BYTE0: if (mem_ready) state_nxt = single_q ? S_DONE : S_BYTE1;
      S_BYTE1: if (mem_ready) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; reset aborts any transfer in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Capture the request once; later input changes cannot disturb the transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= 16'h0000;
      addr_q   <= '0;
      single_q <= 1'b0;
    end else if (accept) begin
      word_q   <= word_in;
      addr_q   <= addr_in;
      single_q <= single;
    end
  end

  // Byte/offset selectors switch only on accept and on the BYTE0->BYTE1 step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_sel_q <= 1'b0;
      off_q    <= 1'b0;
    end else if (accept) begin
      hi_sel_q <= HI_FIRST;
      off_q    <= 1'b0;
    end else if (adv_byte1) begin
      hi_sel_q <= !HI_FIRST;
      off_q    <= 1'b1;
    end
  end

  // Port outputs are decoded purely from registers, so reset clears them at once.
  always_comb begin
    mem_wr   = (state == S_BYTE0) || (state == S_BYTE1);
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    mem_data = hi_sel_q ? word_q[15:8] : word_q[7:0];
    mem_addr = off_q ? (addr_q + ADDR_W'(1)) : addr_q;
  end

endmodule

// File: tb/tb_word_byte_writer.sv
// Directed bench for word_byte_writer: one instance per byte order.
module tb_word_byte_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_lo, start_hi, single, mem_ready;
  logic [15:0] word_in;
  logic [7:0]  addr_in;
  logic        mem_wr_lo, busy_lo, done_lo, mem_wr_hi, busy_hi, done_hi;
  logic [7:0]  mem_addr_lo, mem_data_lo, mem_addr_hi, mem_data_hi;

  int errors = 0;
  int checks = 0;
  int done_cnt_lo = 0;
  int done_cnt_hi = 0;
  logic [15:0] wr_lo_q[$];
  logic [15:0] wr_hi_q[$];

  always #5 clk = ~clk;

  word_byte_writer #(.ADDR_W(8), .HI_FIRST(1'b0)) u_lo (
    .clk(clk), .rst_n(rst_n), .start(start_lo), .single(single),
    .word_in(word_in), .addr_in(addr_in), .mem_ready(mem_ready),
    .mem_wr(mem_wr_lo), .mem_addr(mem_addr_lo), .mem_data(mem_data_lo),
    .busy(busy_lo), .done(done_lo)
  );

  word_byte_writer #(.ADDR_W(8), .HI_FIRST(1'b1)) u_hi (
    .clk(clk), .rst_n(rst_n), .start(start_hi), .single(single),
    .word_in(word_in), .addr_in(addr_in), .mem_ready(mem_ready),
    .mem_wr(mem_wr_hi), .mem_addr(mem_addr_hi), .mem_data(mem_data_hi),
    .busy(busy_hi), .done(done_hi)
  );

  // Memory-side log: a byte lands only when strobe and ready meet at an edge.
  always @(posedge clk) begin
    if (mem_wr_lo && mem_ready) wr_lo_q.push_back({mem_addr_lo, mem_data_lo});
    if (mem_wr_hi && mem_ready) wr_hi_q.push_back({mem_addr_hi, mem_data_hi});
    if (done_lo) done_cnt_lo++;
    if (done_hi) done_cnt_hi++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_lo(input string tag, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, input logic b, input logic dn);
    chk({tag, ".wr"},   32'(mem_wr_lo),   32'(wr));
    chk({tag, ".addr"}, 32'(mem_addr_lo), 32'(a));
    chk({tag, ".data"}, 32'(mem_data_lo), 32'(d));
    chk({tag, ".busy"}, 32'(busy_lo),     32'(b));
    chk({tag, ".done"}, 32'(done_lo),     32'(dn));
  endtask

  initial begin
    rst_n = 1'b0; start_lo = 0; start_hi = 0; single = 0; mem_ready = 1;
    word_in = 16'h0; addr_in = 8'h0;
    @(negedge clk); @(negedge clk);
    chk_lo("reset", 0, 8'h00, 8'h00, 0, 0);
    chk("reset.hi_wr", 32'(mem_wr_hi), 0);
    rst_n = 1'b1;
    step();

    // Basic low-first transfer.
    word_in = 16'hA55A; addr_in = 8'h10; start_lo = 1;
    step(); start_lo = 0;
    chk_lo("basic.b0", 1, 8'h10, 8'h5A, 1, 0);
    step(); chk_lo("basic.b1", 1, 8'h11, 8'hA5, 1, 0);
    step(); chk_lo("basic.done", 0, 8'h11, 8'hA5, 1, 1);
    step(); chk_lo("basic.idle", 0, 8'h11, 8'hA5, 0, 0);
    chk("basic.nwr", 32'(wr_lo_q.size()), 2);
    chk("basic.w0", 32'(wr_lo_q[0]), 32'h105A);
    chk("basic.w1", 32'(wr_lo_q[1]), 32'h11A5);
    chk("basic.ndone", 32'(done_cnt_lo), 1);
    wr_lo_q.delete(); done_cnt_lo = 0;

    // Backpressure: two stall edges in BYTE0, one in BYTE1.
    start_lo = 1;
    step(); start_lo = 0; mem_ready = 0;
    chk_lo("bp.b0", 1, 8'h10, 8'h5A, 1, 0);
    step(); chk_lo("bp.stall0a", 1, 8'h10, 8'h5A, 1, 0);
    step(); chk_lo("bp.stall0b", 1, 8'h10, 8'h5A, 1, 0); mem_ready = 1;
    step(); chk_lo("bp.b1", 1, 8'h11, 8'hA5, 1, 0); mem_ready = 0;
    step(); chk_lo("bp.stall1", 1, 8'h11, 8'hA5, 1, 0); mem_ready = 1;
    step(); chk_lo("bp.done", 0, 8'h11, 8'hA5, 1, 1);
    step(); chk_lo("bp.idle", 0, 8'h11, 8'hA5, 0, 0);
    chk("bp.nwr", 32'(wr_lo_q.size()), 2);
    chk("bp.w0", 32'(wr_lo_q[0]), 32'h105A);
    chk("bp.w1", 32'(wr_lo_q[1]), 32'h11A5);
    chk("bp.ndone", 32'(done_cnt_lo), 1);
    wr_lo_q.delete(); done_cnt_lo = 0;

    // Start while busy is ignored; inputs change after capture.
    word_in = 16'hA55A; addr_in = 8'h10; start_lo = 1;
    step(); word_in = 16'h0000; addr_in = 8'h55;
    chk_lo("ign.b0", 1, 8'h10, 8'h5A, 1, 0);
    step(); start_lo = 0;
    chk_lo("ign.b1", 1, 8'h11, 8'hA5, 1, 0);
    step(); chk_lo("ign.done", 0, 8'h11, 8'hA5, 1, 1);
    step(); chk_lo("ign.idle", 0, 8'h11, 8'hA5, 0, 0);
    step(); chk("ign.noq", 32'(busy_lo), 0);
    chk("ign.nwr", 32'(wr_lo_q.size()), 2);
    chk("ign.w0", 32'(wr_lo_q[0]), 32'h105A);
    chk("ign.w1", 32'(wr_lo_q[1]), 32'h11A5);
    chk("ign.ndone", 32'(done_cnt_lo), 1);
    wr_lo_q.delete(); done_cnt_lo = 0;

    // Single-byte write.
    word_in = 16'hBEEF; addr_in = 8'h20; single = 1; start_lo = 1;
    step(); start_lo = 0; single = 0;
    chk_lo("single.b0", 1, 8'h20, 8'hEF, 1, 0);
    step(); chk_lo("single.done", 0, 8'h20, 8'hEF, 1, 1);
    step(); chk_lo("single.idle", 0, 8'h20, 8'hEF, 0, 0);
    chk("single.nwr", 32'(wr_lo_q.size()), 1);
    chk("single.w0", 32'(wr_lo_q[0]), 32'h20EF);
    chk("single.ndone", 32'(done_cnt_lo), 1);
    wr_lo_q.delete(); done_cnt_lo = 0;

    // High-first order with address wrap.
    word_in = 16'h1234; addr_in = 8'hFF; start_hi = 1;
    step(); start_hi = 0;
    chk("wrap.b0.addr", 32'(mem_addr_hi), 32'hFF);
    chk("wrap.b0.data", 32'(mem_data_hi), 32'h12);
    step();
    chk("wrap.b1.addr", 32'(mem_addr_hi), 32'h00);
    chk("wrap.b1.data", 32'(mem_data_hi), 32'h34);
    step(); chk("wrap.done", 32'(done_hi), 1);
    step(); chk("wrap.idle", 32'(busy_hi), 0);
    chk("wrap.nwr", 32'(wr_hi_q.size()), 2);
    chk("wrap.w0", 32'(wr_hi_q[0]), 32'hFF12);
    chk("wrap.w1", 32'(wr_hi_q[1]), 32'h0034);
    chk("wrap.lo_quiet", 32'(wr_lo_q.size()), 0);

    // Asynchronous reset while in BYTE1.
    word_in = 16'hA55A; addr_in = 8'h10; start_lo = 1;
    step(); start_lo = 0;
    step(); chk_lo("arst.b1", 1, 8'h11, 8'hA5, 1, 0);
    #2 rst_n = 1'b0;
    #1 chk_lo("arst.async", 0, 8'h00, 8'h00, 0, 0);
    step(); rst_n = 1'b1;
    step(); step();
    chk_lo("arst.after", 0, 8'h00, 8'h00, 0, 0);
    chk("arst.nwr", 32'(wr_lo_q.size()), 1);
    chk("arst.ndone", 32'(done_cnt_lo), 0);
    wr_lo_q.delete();
    word_in = 16'h00C3; addr_in = 8'h40; start_lo = 1;
    step(); start_lo = 0;
    chk_lo("arst.new.b0", 1, 8'h40, 8'hC3, 1, 0);
    step(); step(); step();
    chk("arst.new.nwr", 32'(wr_lo_q.size()), 2);
    chk("arst.new.w1", 32'(wr_lo_q[1]), 32'h4100);
    chk("arst.new.ndone", 32'(done_cnt_lo), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
